// File: rtl/dsp_delay_pkg.sv
//------------------------------------------------------------------------------
// Module : dsp_delay_pkg
// Brief  : Shared defaults and in-flight request tag for the sample delay line.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package dsp_delay_pkg;

  localparam int c_DEF_ADDR_W = 16;
  localparam int c_DEF_DATA_W = 16;

  // Tag data is sized to the package default sample width.
  typedef struct packed {
    logic                    valid;
    logic                    use_ram;
    logic [c_DEF_DATA_W-1:0] data;
  } tap_tag_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module : sync_fifo
// Brief  : Single-clock first-word-fall-through FIFO with occupancy count.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW:0]    r_wptr;
  logic [c_PW:0]    r_rptr;
  logic             w_full;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign w_full    = (r_wptr[c_PW] != r_rptr[c_PW]) &&
                     (r_wptr[c_PW-1:0] == r_rptr[c_PW-1:0]);
  assign empty     = (r_wptr == r_rptr);
  assign count     = r_wptr - r_rptr;
  assign head      = r_mem[r_rptr[c_PW-1:0]];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr[c_PW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/delay_tap_reader.sv
//------------------------------------------------------------------------------
// Module : delay_tap_reader
// Brief  : Read tap of the circular delay buffer; one delayed sample per commit.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module delay_tap_reader
  import dsp_delay_pkg::*;
#(
  parameter int ADDR_W     = c_DEF_ADDR_W,
  parameter int DATA_W     = c_DEF_DATA_W,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] delay,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              overflow
);

  localparam int                c_CW       = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] c_FILL_MAX = '1;

  tap_tag_t            r_pipe [RD_LAT];
  tap_tag_t            w_tag;
  tap_tag_t            w_tail;
  logic [ADDR_W-1:0]   r_fill;
  logic [ADDR_W-1:0]   r_last_addr;
  logic                r_overflow;
  logic [ADDR_W-1:0]   w_d_eff;
  logic [ADDR_W-1:0]   w_rd_addr;
  logic                w_primed;
  logic                w_space;
  logic                w_accept;
  logic                w_issue;
  logic [c_CW:0]       w_fifo_cnt;
  logic [c_CW:0]       w_inflight;
  logic [c_CW+1:0]     w_used;
  logic                w_push;
  logic [DATA_W-1:0]   w_push_data;
  logic                w_pop;
  logic [DATA_W-1:0]   w_head;
  logic                w_empty;

  // The delay port is only ADDR_W wide, so it can never exceed the oldest sample.
  assign w_d_eff   = delay;
  assign w_primed  = (r_fill >= w_d_eff);
  assign w_rd_addr = wr_addr - w_d_eff;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      w_inflight = w_inflight + (c_CW+1)'(r_pipe[i].valid);
    end
  end

  // Credit counts requests still in the read pipeline as already occupying the FIFO.
  assign w_used   = {1'b0, w_fifo_cnt} + {1'b0, w_inflight};
  assign w_space  = (w_used < (c_CW+2)'(FIFO_DEPTH));
  assign w_accept = wr_valid && w_space && !rst;
  assign w_issue  = w_accept && (w_d_eff != '0) && w_primed;

  assign mem_re   = w_issue;
  assign mem_addr = w_issue ? w_rd_addr : r_last_addr;

  always_comb begin
    w_tag         = '0;
    w_tag.valid   = w_accept;
    w_tag.use_ram = w_issue;
    if (w_accept && (w_d_eff == '0)) begin
      w_tag.data = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        r_pipe[i] <= '0;
      end
      r_fill      <= '0;
      r_last_addr <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_pipe[0] <= w_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      // Dropped commits still advance warm-up so address alignment holds.
      if (wr_valid && (r_fill != c_FILL_MAX)) begin
        r_fill <= r_fill + 1'b1;
      end
      if (w_issue) begin
        r_last_addr <= w_rd_addr;
      end
      if (wr_valid && !w_space) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_tail      = r_pipe[RD_LAT-1];
  assign w_push      = w_tail.valid;
  assign w_push_data = w_tail.use_ram ? mem_rdata : w_tail.data;

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .head      (w_head),
    .empty     (w_empty),
    .count     (w_fifo_cnt)
  );

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? '0 : w_head;
  assign w_pop     = out_valid && out_ready;
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_delay_tap_reader.sv
//------------------------------------------------------------------------------
// Module : tb_delay_tap_reader
// Brief  : Directed vector bench for delay_tap_reader (16-bit and 4-bit address).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_delay_tap_reader;

  logic        clk;
  logic        rst;
  logic        wr_valid, mem_re, out_valid, out_ready, overflow;
  logic [15:0] wr_addr, wr_data, delay, mem_addr, mem_rdata, out_data;

  logic        d4_wr_valid, d4_mem_re, d4_out_valid, d4_out_ready, d4_overflow;
  logic [3:0]  d4_wr_addr, d4_delay, d4_mem_addr;
  logic [15:0] d4_wr_data, d4_mem_rdata, d4_out_data;

  int n_pass;
  int n_total;

  delay_tap_reader #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .delay(delay), .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .overflow(overflow)
  );

  delay_tap_reader #(.ADDR_W(4), .DATA_W(16), .RD_LAT(1), .FIFO_DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .wr_valid(d4_wr_valid), .wr_addr(d4_wr_addr), .wr_data(d4_wr_data),
    .delay(d4_delay), .mem_re(d4_mem_re), .mem_addr(d4_mem_addr), .mem_rdata(d4_mem_rdata),
    .out_valid(d4_out_valid), .out_data(d4_out_data), .out_ready(d4_out_ready),
    .overflow(d4_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM models with one cycle of read latency: mem[i] = i and mem4[i] = 0xA0 + i.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_addr;
    if (d4_mem_re) d4_mem_rdata <= 16'h00A0 + {12'h000, d4_mem_addr};
  end

  typedef struct {
    logic        rst;
    logic        wv;
    logic [15:0] wa;
    logic [15:0] wd;
    logic [15:0] dl;
    logic        rdy;
    logic        e_re;
    logic [15:0] e_addr;
    logic        e_ov;
    logic [15:0] e_od;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void addv(input logic r, input logic wv, input logic [15:0] wa,
                               input logic [15:0] wd, input logic [15:0] dl, input logic rdy,
                               input logic ere, input logic [15:0] ea, input logic eov,
                               input logic [15:0] eod, input logic eovf);
    vec_t v;
    v.rst = r; v.wv = wv; v.wa = wa; v.wd = wd; v.dl = dl; v.rdy = rdy;
    v.e_re = ere; v.e_addr = ea; v.e_ov = eov; v.e_od = eod; v.e_ovf = eovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s [%0d]: got %h, want %h", name, idx, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [15:0] wa, input logic [15:0] wd,
                       input logic [15:0] dl, input logic rdy);
    wr_valid = wv; wr_addr = wa; wr_data = wd; delay = dl; out_ready = rdy;
  endtask

  initial begin
    vec_t        v;
    logic [15:0] big_delay;
    n_pass = 0; n_total = 0;
    rst = 1'b1;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b1);
    d4_wr_valid = 1'b0; d4_wr_addr = '0; d4_wr_data = '0; d4_delay = '0; d4_out_ready = 1'b1;
    big_delay = 16'hFFFF;

    // Steady state, delay 5, mem[i]=i
    addv(1, 0, 16'h0, 16'h0, 16'd0, 1, 0, 16'h0, 0, 16'h0, 0);
    for (int c = 0; c < 16; c++)
      addv(0, 1, 16'(c), 16'hDEAD, 16'd5, 1, c >= 5, 16'(c - 5), c >= 2,
           (c < 7) ? 16'd0 : 16'(c - 7), 0);
    addv(0, 0, 16'h0, 16'h0, 16'd5, 1, 0, 16'h0, 1, 16'd9, 0);
    addv(0, 0, 16'h0, 16'h0, 16'd5, 1, 0, 16'h0, 1, 16'd10, 0);
    addv(0, 0, 16'h0, 16'h0, 16'd5, 1, 0, 16'h0, 0, 16'h0, 0);
    // Wrap-around, delay 3
    addv(1, 0, 16'h0, 16'h0, 16'd3, 1, 0, 16'h0, 0, 16'h0, 0);
    addv(0, 1, 16'hFFFD, 16'h0, 16'd3, 1, 0, 16'h0, 0, 16'h0, 0);
    addv(0, 1, 16'hFFFE, 16'h0, 16'd3, 1, 0, 16'h0, 0, 16'h0, 0);
    addv(0, 1, 16'hFFFF, 16'h0, 16'd3, 1, 0, 16'h0, 1, 16'h0, 0);
    addv(0, 1, 16'h0000, 16'h0, 16'd3, 1, 1, 16'hFFFD, 1, 16'h0, 0);
    addv(0, 1, 16'h0001, 16'h0, 16'd3, 1, 1, 16'hFFFE, 1, 16'h0, 0);
    addv(0, 0, 16'h0, 16'h0, 16'd3, 1, 0, 16'h0, 1, 16'hFFFD, 0);
    addv(0, 0, 16'h0, 16'h0, 16'd3, 1, 0, 16'h0, 1, 16'hFFFE, 0);
    // Zero-delay bypass
    addv(0, 1, 16'h0002, 16'h1234, 16'd0, 1, 0, 16'h0, 0, 16'h0, 0);
    addv(0, 1, 16'h0003, 16'h5678, 16'd0, 1, 0, 16'h0, 0, 16'h0, 0);
    addv(0, 0, 16'h0, 16'h0, 16'd0, 1, 0, 16'h0, 1, 16'h1234, 0);
    addv(0, 0, 16'h0, 16'h0, 16'd0, 1, 0, 16'h0, 1, 16'h5678, 0);
    addv(0, 0, 16'h0, 16'h0, 16'd0, 1, 0, 16'h0, 0, 16'h0, 0);
    // Backpressure: 6 commits, 4 accepted
    addv(1, 0, 16'h0, 16'h0, 16'd0, 0, 0, 16'h0, 0, 16'h0, 0);
    for (int c = 0; c < 6; c++)
      addv(0, 1, 16'(c), 16'(16'hB1 + c), 16'd0, 0, 0, 16'h0, c >= 2, 16'h00B1, c == 5);
    for (int c = 0; c < 4; c++)
      addv(0, 0, 16'h0, 16'h0, 16'd0, 1, 0, 16'h0, 1, 16'(16'hB1 + c), 1);
    addv(0, 0, 16'h0, 16'h0, 16'd0, 1, 0, 16'h0, 0, 16'h0, 1);

    tick();
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst;
      drive(v.wv, v.wa, v.wd, v.dl, v.rdy);
      #2;
      chk("mem_re", i, {15'h0, mem_re}, {15'h0, v.e_re});
      if (v.e_re || v.rst) chk("mem_addr", i, mem_addr, v.rst ? 16'h0 : v.e_addr);
      chk("out_valid", i, {15'h0, out_valid}, {15'h0, v.e_ov});
      if (v.e_ov || v.rst) chk("out_data", i, out_data, v.rst ? 16'h0 : v.e_od);
      chk("overflow", i, {15'h0, overflow}, {15'h0, v.e_ovf});
      tick();
    end

    // Reset mid-stream: two entries queued, one read in flight
    rst = 1'b1; drive(1'b0, 16'h0, 16'h0, 16'd2, 1'b0); tick();
    rst = 1'b0;
    drive(1'b1, 16'd10, 16'h0, 16'd2, 1'b0); tick();
    drive(1'b1, 16'd11, 16'h0, 16'd2, 1'b0); tick();
    drive(1'b1, 16'd12, 16'h0, 16'd2, 1'b0); #1;
    chk("rs_issue", 0, {15'h0, mem_re}, 16'h1);
    chk("rs_issue_addr", 0, mem_addr, 16'd10);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'd2, 1'b0); #1;
    chk("rs_pre_valid", 0, {15'h0, out_valid}, 16'h1);
    rst = 1'b1; #1;
    chk("rs_async_valid", 0, {15'h0, out_valid}, 16'h0);
    chk("rs_async_data", 0, out_data, 16'h0);
    tick();
    rst = 1'b0;
    drive(1'b1, 16'd20, 16'h0, 16'd2, 1'b1); #1;
    chk("rs_warm_re", 0, {15'h0, mem_re}, 16'h0);
    chk("rs_flush_valid", 0, {15'h0, out_valid}, 16'h0);
    tick();
    drive(1'b1, 16'd21, 16'h0, 16'd2, 1'b1); #1;
    chk("rs_warm_re", 1, {15'h0, mem_re}, 16'h0);
    chk("rs_flush_valid", 1, {15'h0, out_valid}, 16'h0);
    tick();
    drive(1'b1, 16'd22, 16'h0, 16'd2, 1'b1); #1;
    chk("rs_re", 2, {15'h0, mem_re}, 16'h1);
    chk("rs_addr", 2, mem_addr, 16'd20);
    chk("rs_out0", 2, {out_valid, out_data[14:0]}, 16'h8000);
    tick();
    drive(1'b0, 16'h0, 16'h0, 16'd2, 1'b1); #1;
    chk("rs_out1", 3, {out_valid, out_data[14:0]}, 16'h8000);
    tick(); #1;
    chk("rs_out2_valid", 4, {15'h0, out_valid}, 16'h1);
    chk("rs_out2_data", 4, out_data, 16'd20);
    chk("rs_overflow", 4, {15'h0, overflow}, 16'h0);
    tick();

    // Clamp on the 4-bit address instance: delay 16'hFFFF truncates to 15
    for (int n = 0; n < 19; n++) begin
      d4_wr_valid = (n < 17);
      d4_wr_addr  = 4'(n);
      d4_wr_data  = 16'hBEEF;
      d4_delay    = big_delay[3:0];
      #2;
      if (n < 17) chk("clamp_re", n, {15'h0, d4_mem_re}, {15'h0, n >= 15});
      if (n == 15) chk("clamp_addr", n, {12'h0, d4_mem_addr}, 16'h0000);
      if (n == 16) chk("clamp_addr", n, {12'h0, d4_mem_addr}, 16'h0001);
      chk("clamp_valid", n, {15'h0, d4_out_valid}, {15'h0, n >= 2});
      if (n >= 2)
        chk("clamp_data", n, d4_out_data,
            (n - 2 < 15) ? 16'h0 : 16'(16'h00A0 + (n - 2 - 15)));
      tick();
    end
    d4_wr_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/delay_tap_reader.md
Name: delay_tap_reader

Overview:
- Read side of the circular sample delay buffer. A writer stores one processed sample per commit into a RAM whose address counter wraps.
- For each writer commit, this block fetches the sample written `delay` commits earlier and streams it out on a valid/ready interface.
- It sits between the buffer RAM read port and the downstream processor/mixer.
- It handles RAM read latency, warm-up zeros, delay clamping, zero-delay bypass and backpressure buffering.

Parameters:
- ADDR_W, 16, buffer address width; buffer depth is 2**ADDR_W.
- DATA_W, 16, sample width (two's complement).
- RD_LAT, 1, RAM read latency in cycles from mem_re/mem_addr to mem_rdata valid (1..3).
- FIFO_DEPTH, 4, output skid FIFO entries (power of two, ≥ RD_LAT+1).

Ports:
- clk, in, 1, single clock; all logic on posedge.
- rst, in, 1, asynchronous active-high reset.
- wr_valid, in, 1, writer commits a sample this cycle.
- wr_addr, in, ADDR_W, address being written this cycle.
- wr_data, in, DATA_W, sample being written this cycle.
- delay, in, ADDR_W, tap delay in samples; sampled on each wr_valid.
- mem_re, out, 1, RAM read enable.
- mem_addr, out, ADDR_W, RAM read address.
- mem_rdata, in, DATA_W, RAM read data, valid RD_LAT cycles after mem_re.
- out_valid, out, 1, out_data holds a sample.
- out_data, out, DATA_W, delayed sample.
- out_ready, in, 1, downstream accepts the sample when out_valid && out_ready.
- overflow, out, 1, sticky flag: a request was dropped because there was no space.

Behaviour:
- Reset (async assert, sync release): mem_re=0, mem_addr=0, out_valid=0, out_data=0, overflow=0. FIFO empty; pipeline empty; fill_cnt=0.
- Effective delay: d_eff = min(delay, 2**ADDR_W-1). Delays at or beyond the full depth clamp to the oldest stored sample.
- Warm-up: fill_cnt counts wr_valid commits and saturates at 2**ADDR_W-1. Call the n-th commit (n = fill_cnt before increment) primed when n ≥ d_eff.
- Request issue, in the cycle wr_valid=1 and space is available:
  - d_eff == 0: no RAM read; the request carries wr_data directly (bypass, avoiding the read-during-write hazard).
  - d_eff > 0 and primed: mem_re=1, mem_addr = wr_addr − d_eff (mod 2**ADDR_W, natural wrap).
  - d_eff > 0 and not primed: no RAM read; the request carries zero.
- In-flight tracking: every accepted request enters an RD_LAT-deep shift pipeline tagged {valid, use_ram, bypass_data}.
- FIFO write: at the pipeline tail, if valid, push (use_ram ? mem_rdata : bypass_data) into the FIFO. Output order always equals commit order.
- Space/credit: space = (FIFO occupancy + in-flight count) < FIFO_DEPTH, evaluated before this cycle's pop.
  - If wr_valid=1 and no space: the request is dropped, overflow←1 (sticky until rst), and fill_cnt still increments so address alignment is unaffected.
- mem_re is 0 in every cycle without an accepted RAM request. mem_addr holds its last value.
- Output: out_valid = FIFO non-empty; out_data = FIFO head (first-word fall-through); pop on out_valid && out_ready.
  - Simultaneous push and pop on a full FIFO is legal. The credit rule guarantees no push when full without a pop.
- Latency with out_ready=1 and an empty FIFO: commit at cycle t → out_valid at t+RD_LAT+1. The same latency applies to bypass and zero requests.
- A delay change takes effect on the next commit; no interpolation. Previously issued requests are unaffected.
- Reset mid-operation: in-flight reads are discarded, the FIFO is flushed, and warm-up restarts.

Decomposition:
- Shared package dsp_delay_pkg: ADDR_W/DATA_W defaults and the request tag struct {valid, use_ram, data}.
- One sub-module: sync_fifo (parameterised width/depth, FWFT, with count output). It is reusable elsewhere in the DSP chain.
- Address arithmetic, clamping, warm-up and credit logic stay in the top module.

Test Plan:
- Steady state: RAM preloaded mem[i]=i, delay=5, wr_valid every cycle with wr_addr 0,1,2…, out_ready=1.
  - Required: first 5 outputs are 0; commit at wr_addr=10 issues mem_addr=5; output 5 appears 2 cycles after that commit (RD_LAT=1).
- Wrap-around: delay=3, commit at wr_addr=1 after ≥3 commits.
  - Required: mem_addr=16'hFFFE and out_data=mem[16'hFFFE].
- Zero-delay bypass: delay=0, wr_data=16'h1234.
  - Required: mem_re stays 0; out_data=16'h1234 two cycles later.
- Clamp: delay=16'hFFFF with ADDR_W=4.
  - Required: d_eff=15; the first 15 outputs are 0; the 16th commit reads wr_addr−15.
- Backpressure: out_ready=0 with 6 back-to-back commits (FIFO_DEPTH=4).
  - Required: exactly 4 accepted; commits 5–6 dropped; overflow=1; after out_ready=1 the 4 samples drain in order and overflow stays 1.
- Reset mid-stream: assert rst with 2 entries in the FIFO and 1 read in flight.
  - Required: out_valid=0 immediately (async); after release, outputs are 0 again for d_eff commits.
